// File: rtl/tdc_meas_ctrl_if.sv
// tdc_meas_ctrl_if: valid/ready result stream carrying interval data and flags
interface tdc_meas_ctrl_if #(parameter int DATA_W = 53);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [1:0]        m_flags;
  modport master(output m_valid, m_data, m_flags, input m_ready);
  modport slave(input m_valid, m_data, m_flags, output m_ready);
endinterface

// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: TDC measurement sequencer with FWFT result FIFO; TDC_TIMEOUT_EN enables the WAIT_STOP timeout
module tdc_meas_ctrl #(
  parameter int BIN_W       = 5,
  parameter int COUNT_W     = 48,
  parameter int PIPE_LAT    = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        arm_i,
  input  logic                        continuous_i,
  input  logic                        start_valid_i,
  input  logic                        stop_valid_i,
  input  logic                        finish_i,
  input  logic [BIN_W-1:0]            bin_start_i,
  input  logic [BIN_W-1:0]            bin_stop_i,
  input  logic [COUNT_W-1:0]          count_i,
  output logic                        tdc_enable_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic                        overflow_o,
  input  logic                        clear_ovf_i,
  tdc_meas_ctrl_if.master             m
);
  localparam int DW = COUNT_W + BIN_W;
  localparam int DW1 = DW + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [2:0] S_IDLE = 3'd0, S_WSTART = 3'd1, S_WSTOP = 3'd2,
                         S_SETTLE = 3'd3, S_COMPUTE = 3'd4, S_PUSH = 3'd5;
  logic [2:0]          state_q, state_d;
  logic [PIPE_LAT-1:0] spipe_q, ppipe_q;
  logic [BIN_W-1:0]    bs_q, bp_q;
  logic [COUNT_W-1:0]  cnt_q;
  logic [DW-1:0]       res_q, res_d;
  logic [1:0]          flg_q, flg_d;
  logic [DW:0]         diff;
  logic                start_hit, stop_hit, timeout;
  logic [DW+1:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]       rd_q, wr_q;
  logic [AW:0]         lvl_q;
  logic                ovf_q, pop, push, full, wr_en, drop;
  logic                unused_ok;
  assign start_hit = state_q == S_WSTART && start_valid_i;
  assign stop_hit  = state_q == S_WSTOP && stop_valid_i;
`ifdef TDC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] to_q;
  // cycles spent in WAIT_STOP; held at zero elsewhere so entry always starts fresh
  always_ff @(posedge clk)
    to_q <= (!reset_n || state_q != S_WSTOP) ? '0 : to_q + TW'(1);
  assign timeout   = state_q == S_WSTOP && !stop_valid_i && to_q == TO_LAST;
  assign unused_ok = finish_i;
`else
  assign timeout   = 1'b0;
  assign unused_ok = ^{finish_i, TIMEOUT_CYC};
`endif
  // measurement sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = (arm_i || continuous_i) ? S_WSTART : S_IDLE;
      S_WSTART:  state_d = start_valid_i ? S_WSTOP : S_WSTART;
      S_WSTOP:   state_d = stop_valid_i ? S_SETTLE : timeout ? S_PUSH : S_WSTOP;
      S_SETTLE:  state_d = ppipe_q[PIPE_LAT-1] ? S_COMPUTE : S_SETTLE;
      S_COMPUTE: state_d = S_PUSH;
      S_PUSH:    state_d = continuous_i ? S_WSTART : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end
  assign diff  = {1'b0, cnt_q, {BIN_W{1'b0}}} + DW1'(bs_q) - DW1'(bp_q);
  assign res_d = timeout ? {DW{1'b1}} : (state_q == S_COMPUTE) ? (diff[DW] ? '0 : diff[DW-1:0]) : res_q;
  assign flg_d = timeout ? 2'b10 : (state_q == S_COMPUTE) ? {1'b0, diff[DW]} : flg_q;
  // FSM state and delayed strobes marking when encoder outputs become valid
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      spipe_q <= '0;
      ppipe_q <= '0;
    end else begin
      state_q <= state_d;
      spipe_q <= (spipe_q << 1) | PIPE_LAT'(start_hit);
      ppipe_q <= (ppipe_q << 1) | PIPE_LAT'(stop_hit);
    end
  end
  // bin/count capture and result register; contents only matter once pushed
  always_ff @(posedge clk) begin
    if (spipe_q[PIPE_LAT-1]) bs_q <= bin_start_i;
    if (ppipe_q[PIPE_LAT-1]) begin
      bp_q  <= bin_stop_i;
      cnt_q <= count_i;
    end
    res_q <= res_d;
    flg_q <= flg_d;
  end
  assign pop   = m.m_valid && m.m_ready;
  assign push  = state_q == S_PUSH;
  assign full  = lvl_q == LW'(FIFO_DEPTH);
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;
  // FIFO pointers, level and sticky overflow
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_q + AW'(pop);
      wr_q  <= wr_q + AW'(wr_en);
      lvl_q <= lvl_q + LW'(wr_en) - LW'(pop);
      ovf_q <= drop || (ovf_q && !clear_ovf_i);
    end
  end
  // FIFO storage
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q] <= {flg_q, res_q};
  assign m.m_valid    = lvl_q != '0;
  assign {m.m_flags, m.m_data} = m.m_valid ? mem_q[rd_q] : '0;
  assign tdc_enable_o = state_q == S_WSTART || state_q == S_WSTOP;
  assign busy_o       = state_q != S_IDLE;
  assign fifo_level_o = lvl_q;
  assign overflow_o   = ovf_q;
endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// tb_tdc_meas_ctrl: random and directed checks of tdc_meas_ctrl against an event-time model
module tb_tdc_meas_ctrl;
  localparam int BW = 5, CW = 48, PL = 2, FD = 4, TO = 16, DW = 53;
`ifdef TDC_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  logic clk = 0, reset_n = 0, arm = 0, cont = 0, sv = 0, pv = 0, fin = 0, clr = 0;
  logic [BW-1:0] bs = 0, bp = 0;
  logic [CW-1:0] cnt = 0;
  logic en, busy, ovf;
  logic [2:0] lvl;
  tdc_meas_ctrl_if #(.DATA_W(DW)) mif();
  tdc_meas_ctrl #(.BIN_W(BW), .COUNT_W(CW), .PIPE_LAT(PL), .FIFO_DEPTH(FD), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n), .arm_i(arm), .continuous_i(cont), .start_valid_i(sv),
    .stop_valid_i(pv), .finish_i(fin), .bin_start_i(bs), .bin_stop_i(bp), .count_i(cnt),
    .tdc_enable_o(en), .busy_o(busy), .fifo_level_o(lvl), .overflow_o(ovf),
    .clear_ovf_i(clr), .m(mif));
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: phase 0 idle, 1 waiting start, 2 waiting stop, 3 finishing; events keyed by edge number
  int ph = 0;
  longint e = 0, cap_s = -1, cap_p = -1, push_e = -1, start_e = -1;
  bit tmo = 0, m_ovf = 0;
  logic [BW-1:0] ms_bs = 0, ms_bp = 0;
  logic [CW-1:0] ms_cnt = 0;
  logic [DW+1:0] q[$];
  task automatic model_step();
    bit do_push, drop;
    longint v;
    logic [DW+1:0] ent;
    e++;
    if (!reset_n) begin
      ph = 0; q.delete(); m_ovf = 0; cap_s = -1; cap_p = -1; push_e = -1;
      return;
    end
    if (e == cap_s) ms_bs = bs;
    if (e == cap_p) begin ms_bp = bp; ms_cnt = cnt; end
    do_push = ph == 3 && e == push_e;
    if (q.size() > 0 && mif.m_ready) void'(q.pop_front());
    drop = 0;
    if (do_push) begin
      v = longint'(ms_cnt) * 32 + longint'(ms_bs) - longint'(ms_bp);
      ent = tmo ? {2'b10, {DW{1'b1}}} : (v < 0) ? {2'b01, {DW{1'b0}}} : {2'b00, v[DW-1:0]};
      if (q.size() < FD) q.push_back(ent); else drop = 1;
    end
    m_ovf = drop ? 1'b1 : clr ? 1'b0 : m_ovf;
    case (ph)
      0: if (arm || cont) ph = 1;
      1: if (sv) begin ph = 2; start_e = e; cap_s = e + PL; end
      2: if (pv) begin ph = 3; cap_p = e + PL; push_e = e + PL + 2; tmo = 0; end
         else if (TMO_EN && e == start_e + TO) begin ph = 3; push_e = e + 1; tmo = 1; end
      default: if (e == push_e) ph = cont ? 1 : 0;
    endcase
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  // compare every output against the model each cycle
  always @(negedge clk) if (chk_en) begin
    chk("busy", busy, ph != 0);
    chk("tdc_enable", en, ph == 1 || ph == 2);
    chk("m_valid", mif.m_valid, q.size() > 0);
    chk("fifo_level", lvl, q.size());
    chk("overflow", ovf, m_ovf);
    chk("head", {mif.m_flags, mif.m_data}, q.size() > 0 ? q[0] : '0);
  end
  task automatic meas(input logic [CW-1:0] c, input logic [BW-1:0] b0, input logic [BW-1:0] b1, input bit rdy_push);
    cnt = c; bs = b0; bp = b1;
    arm = 1; tick(); arm = 0;
    sv = 1; tick(); sv = 0;
    pv = 1; tick(); pv = 0;
    tick(); tick(); tick();
    mif.m_ready = rdy_push; tick(); mif.m_ready = 0;
  endtask
  logic [DW-1:0] drain_exp [4];
  initial begin
    mif.m_ready = 0;
    tick(); tick(); reset_n = 1; chk_en = 1;
    chk("rst_level", lvl, 0);
    chk("rst_busy", busy, 0);
    cnt = 3; bs = 10; bp = 4;
    arm = 1; tick(); arm = 0;
    sv = 1; tick(); sv = 0;
    pv = 1; tick(); pv = 0;
    tick(); tick(); tick();
    chk("t1_not_yet", mif.m_valid, 0);
    tick();
    chk("t1_valid", mif.m_valid, 1);
    chk("t1_data", mif.m_data, 102);
    chk("t1_flags", mif.m_flags, 0);
    mif.m_ready = 1; tick(); mif.m_ready = 0;
    meas(0, 2, 9, 0);
    chk("t2_data", mif.m_data, 0);
    chk("t2_flags", mif.m_flags, 2'b01);
    mif.m_ready = 1; tick(); mif.m_ready = 0;
    cont = 1;
    for (int k = 1; k <= 5; k++) meas(CW'(k), 0, 0, 0);
    chk("t3_level", lvl, 4);
    chk("t3_ovf", ovf, 1);
    chk("t3_head", mif.m_data, 32);
    clr = 1; tick(); clr = 0;
    chk("t3_clear", ovf, 0);
    meas(6, 0, 0, 1);
    chk("t4_level", lvl, 4);
    chk("t4_ovf", ovf, 0);
    cont = 0;
    drain_exp = '{64, 96, 128, 192};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), mif.m_data, drain_exp[i]);
      mif.m_ready = 1; tick(); mif.m_ready = 0;
    end
    chk("drain_empty", lvl, 0);
    meas(1, 0, 0, 0);
    meas(2, 0, 0, 0);
    arm = 1; tick(); arm = 0;
    sv = 1; tick(); sv = 0;
    chk("t5_wait_stop", en, 1);
    chk("t5_queued", lvl, 2);
    reset_n = 0; tick(); reset_n = 1;
    chk("t5_en", en, 0);
    chk("t5_busy", busy, 0);
    chk("t5_valid", mif.m_valid, 0);
    chk("t5_level", lvl, 0);
    arm = 1; tick(); arm = 0;
    sv = 1; tick(); sv = 0;
    repeat (20) tick();
`ifdef TDC_TIMEOUT_EN
    chk("t6_valid", mif.m_valid, 1);
    chk("t6_flags", mif.m_flags, 2'b10);
    chk("t6_data", mif.m_data, {DW{1'b1}});
`else
    chk("t6_busy", busy, 1);
    chk("t6_valid", mif.m_valid, 0);
`endif
    reset_n = 0; tick(); reset_n = 1;
    repeat (3000) begin
      arm = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 49) == 0) cont = ~cont;
      sv = $urandom_range(0, 4) == 0;
      pv = $urandom_range(0, 4) == 0;
      fin = $urandom_range(0, 1) == 0;
      mif.m_ready = $urandom_range(0, 2) == 0;
      clr = $urandom_range(0, 19) == 0;
      reset_n = $urandom_range(0, 299) != 0;
      bs = BW'($urandom);
      bp = BW'($urandom);
      cnt = $urandom_range(0, 1) ? CW'($urandom_range(0, 2)) : CW'({$urandom, $urandom});
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
